// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for the shared RV32I ALU: arbitrate, latch operands, one-hot issue, hold result.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins contention) instead of round-robin.
module alu_arbiter #(
   parameter int XLEN = 32,
   parameter int OP_W = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_valid_i,
   output logic            req0_ready_o,
   input  logic [OP_W-1:0] req0_op_i,
   input  logic [XLEN-1:0] req0_pc_i,
   input  logic [XLEN-1:0] req0_src1_i,
   input  logic [XLEN-1:0] req0_src2_i,
   input  logic [XLEN-1:0] req0_imm_i,
   input  logic            req0_imm_sel_i,
   input  logic            req1_valid_i,
   output logic            req1_ready_o,
   input  logic [OP_W-1:0] req1_op_i,
   input  logic [XLEN-1:0] req1_pc_i,
   input  logic [XLEN-1:0] req1_src1_i,
   input  logic [XLEN-1:0] req1_src2_i,
   input  logic [XLEN-1:0] req1_imm_i,
   input  logic            req1_imm_sel_i,
   output logic            rsp0_valid_o,
   input  logic            rsp0_ready_i,
   output logic [XLEN-1:0] rsp0_data_o,
   output logic            rsp0_err_o,
   output logic            rsp1_valid_o,
   input  logic            rsp1_ready_i,
   output logic [XLEN-1:0] rsp1_data_o,
   output logic            rsp1_err_o,
   output logic [XLEN-1:0] alu_pc_o,
   output logic [XLEN-1:0] alu_src1_o,
   output logic [XLEN-1:0] alu_src2_o,
   output logic [XLEN-1:0] alu_imm_o,
   output logic            alu_imm_sel_o,
   output logic            alu_add_en_o,
   output logic            alu_sub_en_o,
   output logic            alu_and_en_o,
   output logic            alu_or_en_o,
   output logic            alu_xor_en_o,
   output logic            alu_sll_en_o,
   output logic            alu_srl_en_o,
   output logic            alu_sra_en_o,
   output logic            alu_slt_en_o,
   output logic            alu_jalr_en_o,
   output logic            alu_jal_en_o,
   output logic            alu_auipc_en_o,
   output logic            alu_lui_en_o,
   input  logic [XLEN-1:0] alu_result_i
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

   state_e            state_q, state_d;
   logic              owner_q;
   logic [OP_W-1:0]   op_q;
   logic [XLEN-1:0]   pc_q, src1_q, src2_q, imm_q, data_q;
   logic              imm_sel_q, err_q;
   logic              any_vld, accept, winner, illegal, owner_rsp_rdy;
   logic [12:0]       en_vec;

   assign any_vld       = req0_valid_i | req1_valid_i;
   assign accept        = (state_q == S_IDLE) && any_vld;
   assign illegal       = op_q > OP_W'(12);
   assign owner_rsp_rdy = owner_q ? rsp1_ready_i : rsp0_ready_i;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign winner = ~req0_valid_i;
`else
   logic last_grant_q;

   // On contention the port that did not win last time is served.
   assign winner = (req0_valid_i && req1_valid_i) ? ~last_grant_q : req1_valid_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      last_grant_q <= 1'b1;
      else if (accept) last_grant_q <= winner;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (any_vld) state_d = S_ISSUE;
         S_ISSUE: state_d = S_RESP;
         S_RESP:  if (owner_rsp_rdy) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req0_ready_o = accept & ~winner;
      req1_ready_o = accept & winner;
      rsp0_valid_o = (state_q == S_RESP) & ~owner_q;
      rsp1_valid_o = (state_q == S_RESP) & owner_q;
      en_vec       = '0;
      if (state_q == S_ISSUE) begin
         for (int i = 0; i < 13; i++) begin
            if (op_q == OP_W'(i)) en_vec[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q   <= 1'b0;
         op_q      <= '0;
         pc_q      <= '0;
         src1_q    <= '0;
         src2_q    <= '0;
         imm_q     <= '0;
         imm_sel_q <= 1'b0;
         data_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            owner_q   <= winner;
            op_q      <= winner ? req1_op_i      : req0_op_i;
            pc_q      <= winner ? req1_pc_i      : req0_pc_i;
            src1_q    <= winner ? req1_src1_i    : req0_src1_i;
            src2_q    <= winner ? req1_src2_i    : req0_src2_i;
            imm_q     <= winner ? req1_imm_i     : req0_imm_i;
            imm_sel_q <= winner ? req1_imm_sel_i : req0_imm_sel_i;
         end
         if (state_q == S_ISSUE) begin
            data_q <= illegal ? '0 : alu_result_i;
            err_q  <= illegal;
         end
      end
   end

   assign rsp0_data_o    = data_q;
   assign rsp1_data_o    = data_q;
   assign rsp0_err_o     = err_q;
   assign rsp1_err_o     = err_q;
   assign alu_pc_o       = pc_q;
   assign alu_src1_o     = src1_q;
   assign alu_src2_o     = src2_q;
   assign alu_imm_o      = imm_q;
   assign alu_imm_sel_o  = imm_sel_q;
   assign alu_add_en_o   = en_vec[0];
   assign alu_sub_en_o   = en_vec[1];
   assign alu_and_en_o   = en_vec[2];
   assign alu_or_en_o    = en_vec[3];
   assign alu_xor_en_o   = en_vec[4];
   assign alu_sll_en_o   = en_vec[5];
   assign alu_srl_en_o   = en_vec[6];
   assign alu_sra_en_o   = en_vec[7];
   assign alu_slt_en_o   = en_vec[8];
   assign alu_jalr_en_o  = en_vec[9];
   assign alu_jal_en_o   = en_vec[10];
   assign alu_auipc_en_o = en_vec[11];
   assign alu_lui_en_o   = en_vec[12];

endmodule
